// File: rtl/dcache_perf_pkg.sv
// Shared event codes and the per-cycle access classifier for the dcache performance monitor.
package dcache_perf_pkg;

  localparam int NUM_EVT = 6;

  localparam logic [2:0] EVT_RD_HIT  = 3'd0;
  localparam logic [2:0] EVT_RD_MISS = 3'd1;
  localparam logic [2:0] EVT_WR_HIT  = 3'd2;
  localparam logic [2:0] EVT_WR_MISS = 3'd3;
  localparam logic [2:0] EVT_WB      = 3'd4;
  localparam logic [2:0] EVT_STALL   = 3'd5;

  typedef struct packed {
    logic [NUM_EVT-1:0] inc;
    logic               valid;
    logic [2:0]         code;
  } chan_class_t;

  // A miss cycle is the controller accepting a request while stalling; the retry that
  // completes the miss (first non-stall cycle with in_miss set) is deliberately not a hit.
  function automatic chan_class_t classify(input logic stall, input logic ctrl_idle,
                                           input logic dirty, input logic rd,
                                           input logic wr, input logic in_miss);
    chan_class_t r;
    r = '0;
    if (stall && ctrl_idle) begin
      if (wr) begin
        r.valid = 1'b1;
        r.code  = EVT_WR_MISS;
        r.inc[EVT_WR_MISS] = 1'b1;
      end else if (rd) begin
        r.valid = 1'b1;
        r.code  = EVT_RD_MISS;
        r.inc[EVT_RD_MISS] = 1'b1;
      end
      if (dirty) r.inc[EVT_WB] = 1'b1;
    end else if (!stall && !in_miss) begin
      if (wr) begin
        r.valid = 1'b1;
        r.code  = EVT_WR_HIT;
        r.inc[EVT_WR_HIT] = 1'b1;
      end else if (rd) begin
        r.valid = 1'b1;
        r.code  = EVT_RD_HIT;
        r.inc[EVT_RD_HIT] = 1'b1;
      end
    end
    if (stall) r.inc[EVT_STALL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dcache_perf_chan.sv
// One monitored cache port: classifier, in_miss tracking, six event counters and a sticky overflow bit.
module dcache_perf_chan
  import dcache_perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     stall,
  input  logic                     ctrl_idle,
  input  logic                     dirty,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic [NUM_EVT*CNT_W-1:0] counts,
  output logic                     ovf,
  output logic                     evt_valid,
  output logic [2:0]               evt_code
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              in_miss;
  chan_class_t       cls;
  logic [CNT_W-1:0]  cnt [NUM_EVT];

  always_comb begin
    cls = classify(stall, ctrl_idle, dirty, mem_read, mem_write, in_miss);
  end

  // in_miss ignores enable so that turning counting on mid-miss still suppresses the retry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_miss <= 1'b0;
    end else if (clear) begin
      in_miss <= 1'b0;
    end else if (stall && ctrl_idle) begin
      in_miss <= 1'b1;
    end else if (!stall) begin
      in_miss <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_EVT; e++) cnt[e] <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      for (int e = 0; e < NUM_EVT; e++) cnt[e] <= '0;
      ovf <= 1'b0;
    end else if (enable) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (cls.inc[e]) begin
          if (cnt[e] == CNT_MAX) begin
            ovf <= 1'b1;
            if (!SATURATE) cnt[e] <= '0;
          end else begin
            cnt[e] <= cnt[e] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
    end else if (clear) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
    end else begin
      evt_valid <= enable & cls.valid;
      evt_code  <= (enable && cls.valid) ? cls.code : 3'd0;
    end
  end

  always_comb begin
    counts = '0;
    for (int e = 0; e < NUM_EVT; e++) counts[e*CNT_W +: CNT_W] = cnt[e];
  end

endmodule

// File: rtl/dcache_perf_monitor.sv
// Multi-channel dcache performance monitor: per-port counter channels plus a registered readout mux.
module dcache_perf_monitor
  import dcache_perf_pkg::*;
#(
  parameter int NUM_CH   = 1,
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [NUM_CH-1:0]   stall_i,
  input  logic [NUM_CH-1:0]   ctrl_idle_i,
  input  logic [NUM_CH-1:0]   dirty_i,
  input  logic [NUM_CH-1:0]   mem_read_i,
  input  logic [NUM_CH-1:0]   mem_write_i,
  input  logic [2:0]          sel_ch_i,
  input  logic [2:0]          sel_evt_i,
  output logic [CNT_W-1:0]    count_o,
  output logic [NUM_CH-1:0]   ovf_o,
  output logic [NUM_CH-1:0]   evt_valid_o,
  output logic [3*NUM_CH-1:0] evt_code_o
);

  logic [NUM_EVT*CNT_W-1:0] ch_counts [NUM_CH];
  logic [CNT_W-1:0]         sel_value;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    dcache_perf_chan #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .enable    (enable_i),
      .clear     (clear_i),
      .stall     (stall_i[c]),
      .ctrl_idle (ctrl_idle_i[c]),
      .dirty     (dirty_i[c]),
      .mem_read  (mem_read_i[c]),
      .mem_write (mem_write_i[c]),
      .counts    (ch_counts[c]),
      .ovf       (ovf_o[c]),
      .evt_valid (evt_valid_o[c]),
      .evt_code  (evt_code_o[3*c +: 3])
    );
  end

  // Unmatched selects (channel beyond NUM_CH, event codes 6-7) fall through to zero.
  always_comb begin
    sel_value = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (sel_ch_i == 3'(c) && sel_evt_i == 3'(e)) sel_value = ch_counts[c][e*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) count_o <= '0;
    else        count_o <= sel_value;
  end

endmodule

// File: tb/tb_dcache_perf_monitor.sv
// Directed bench: stimulus pushes expected event pulses into a queue, a negedge monitor pops and compares.
module tb_dcache_perf_monitor;
  import dcache_perf_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b1;
  logic        clear_i = 1'b0;
  logic [1:0]  stall = '0, idle = '0, dirty = '0, rd = '0, wr = '0;
  logic [2:0]  sel_ch = '0, sel_evt = '0;
  logic [31:0] count;
  logic [1:0]  ovf, evt_valid;
  logic [5:0]  evt_code;

  logic        rd8 = 1'b0;
  logic [7:0]  count8s, count8w;
  logic        ovf8s, ovf8w, ev8s, ev8w;
  logic [2:0]  code8s, code8w;

  typedef struct {
    int         due;
    logic [1:0] valid;
    logic [5:0] code;
  } exp_evt_t;

  exp_evt_t exp_q[$];
  exp_evt_t mon_e;
  logic [5:0] mon_mask;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  dcache_perf_monitor #(.NUM_CH(2), .CNT_W(32), .SATURATE(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .stall_i(stall), .ctrl_idle_i(idle), .dirty_i(dirty), .mem_read_i(rd), .mem_write_i(wr),
    .sel_ch_i(sel_ch), .sel_evt_i(sel_evt), .count_o(count), .ovf_o(ovf),
    .evt_valid_o(evt_valid), .evt_code_o(evt_code)
  );

  dcache_perf_monitor #(.NUM_CH(1), .CNT_W(8), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .stall_i(1'b0), .ctrl_idle_i(1'b0), .dirty_i(1'b0), .mem_read_i(rd8), .mem_write_i(1'b0),
    .sel_ch_i(3'd0), .sel_evt_i(3'd0), .count_o(count8s), .ovf_o(ovf8s),
    .evt_valid_o(ev8s), .evt_code_o(code8s)
  );

  dcache_perf_monitor #(.NUM_CH(1), .CNT_W(8), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .stall_i(1'b0), .ctrl_idle_i(1'b0), .dirty_i(1'b0), .mem_read_i(rd8), .mem_write_i(1'b0),
    .sel_ch_i(3'd0), .sel_evt_i(3'd0), .count_o(count8w), .ovf_o(ovf8w),
    .evt_valid_o(ev8w), .evt_code_o(code8w)
  );

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle on the 2-channel DUT; a nonzero ev means pulses are due one edge later.
  task automatic applyStimulus(input logic [1:0] st, input logic [1:0] id, input logic [1:0] dt,
                               input logic [1:0] r, input logic [1:0] w,
                               input logic [1:0] ev, input logic [5:0] ec);
    stall = st; idle = id; dirty = dt; rd = r; wr = w;
    if (ev != 2'b00) exp_q.push_back('{due: cyc + 1, valid: ev, code: ec});
    @(negedge clk_i);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] ch, input logic [2:0] ev,
                             input logic [31:0] exp);
    stall = '0; idle = '0; dirty = '0; rd = '0; wr = '0;
    sel_ch = ch; sel_evt = ev;
    @(negedge clk_i);
    compare(name, 64'(count), 64'(exp));
  endtask

  always @(negedge clk_i) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      tests++;
      fails++;
      $display("[TB] FAIL evt_missing: got no pulse at cycle %0d, expected valid %b", exp_q[0].due, exp_q[0].valid);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      mon_mask = {{3{mon_e.valid[1]}}, {3{mon_e.valid[0]}}};
      compare("evt_valid", 64'(evt_valid), 64'(mon_e.valid));
      compare("evt_code", 64'(evt_code & mon_mask), 64'(mon_e.code & mon_mask));
    end else begin
      compare("evt_quiet", 64'(evt_valid), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    compare("reset_count", 64'(count), 64'd0);
    compare("reset_ovf", 64'(ovf), 64'd0);
    compare("reset_count8", 64'(count8s), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    repeat (3) applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 6'd0);
    checkOutput("t1_rd_hit", 3'd0, EVT_RD_HIT, 32'd3);
    for (int e = 1; e < NUM_EVT; e++) checkOutput("t1_other_zero", 3'd0, 3'(e), 32'd0);

    // Clean write miss, four busy stall cycles, then the suppressed retry.
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 6'd3);
    repeat (4) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 6'd0);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 6'd0);
    checkOutput("t2_wr_miss", 3'd0, EVT_WR_MISS, 32'd1);
    checkOutput("t2_wb", 3'd0, EVT_WB, 32'd0);
    checkOutput("t2_stall", 3'd0, EVT_STALL, 32'd5);
    checkOutput("t2_wr_hit", 3'd0, EVT_WR_HIT, 32'd0);

    applyStimulus(2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 6'd1);
    repeat (2) applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'd0);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'd0);
    checkOutput("t3_rd_miss", 3'd0, EVT_RD_MISS, 32'd1);
    checkOutput("t3_wb", 3'd0, EVT_WB, 32'd1);
    checkOutput("t3_stall", 3'd0, EVT_STALL, 32'd8);
    checkOutput("t3_rd_hit", 3'd0, EVT_RD_HIT, 32'd3);

    // Miss while disabled, then the retry after enabling must not count as a hit.
    enable_i = 1'b0;
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 6'd0);
    enable_i = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'd0);
    checkOutput("en_rd_hit", 3'd0, EVT_RD_HIT, 32'd3);
    checkOutput("en_rd_miss", 3'd0, EVT_RD_MISS, 32'd1);
    checkOutput("en_stall", 3'd0, EVT_STALL, 32'd8);

    applyStimulus(2'b10, 2'b10, 2'b00, 2'b11, 2'b10, 2'b11, 6'b011_000);
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 6'b000_010);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 6'b000_000);
    checkOutput("t5_ch0_rd_hit", 3'd0, EVT_RD_HIT, 32'd5);
    checkOutput("t5_ch0_wr_hit", 3'd0, EVT_WR_HIT, 32'd1);
    checkOutput("t5_ch1_wr_miss", 3'd1, EVT_WR_MISS, 32'd1);
    checkOutput("t5_ch1_rd_miss", 3'd1, EVT_RD_MISS, 32'd0);
    checkOutput("t5_ch1_stall", 3'd1, EVT_STALL, 32'd2);
    checkOutput("t5_ch1_rd_hit", 3'd1, EVT_RD_HIT, 32'd0);
    checkOutput("sel_ch_range", 3'd2, EVT_RD_HIT, 32'd0);
    checkOutput("sel_evt_6", 3'd0, 3'd6, 32'd0);

    clear_i = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'd0);
    clear_i = 1'b0;
    checkOutput("clr_ch0_rd_hit", 3'd0, EVT_RD_HIT, 32'd0);
    checkOutput("clr_ch1_wr_miss", 3'd1, EVT_WR_MISS, 32'd0);
    checkOutput("clr_ch0_stall", 3'd0, EVT_STALL, 32'd0);

    // Reset asserted while ch0 is mid-miss.
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 6'd1);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'd0);
    stall = '0; idle = '0; rd = '0;
    sel_ch = 3'd0; sel_evt = EVT_STALL;
    rst_i = 1'b0;
    @(negedge clk_i);
    compare("rst_mid_count", 64'(count), 64'd0);
    compare("rst_mid_ovf", 64'(ovf), 64'd0);
    compare("rst_mid_evt", 64'(evt_valid), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 6'd0);
    checkOutput("t6_rd_hit", 3'd0, EVT_RD_HIT, 32'd1);
    checkOutput("t6_stall", 3'd0, EVT_STALL, 32'd0);

    rd8 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk_i);
      if (i == 10) begin
        compare("sat_evt_valid", 64'(ev8s & ev8w), 64'd1);
        compare("sat_evt_code", 64'(code8s | code8w), 64'd0);
      end
    end
    rd8 = 1'b0;
    @(negedge clk_i);
    compare("sat_255_count", 64'(count8s), 64'd255);
    compare("sat_255_ovf", 64'(ovf8s), 64'd0);
    compare("wrap_255_count", 64'(count8w), 64'd255);
    compare("wrap_255_ovf", 64'(ovf8w), 64'd0);
    rd8 = 1'b1;
    repeat (45) @(negedge clk_i);
    rd8 = 1'b0;
    @(negedge clk_i);
    compare("sat_300_count", 64'(count8s), 64'd255);
    compare("sat_300_ovf", 64'(ovf8s), 64'd1);
    compare("wrap_300_count", 64'(count8w), 64'd44);
    compare("wrap_300_ovf", 64'(ovf8w), 64'd1);
    compare("main_ovf", 64'(ovf), 64'd0);

    repeat (2) @(negedge clk_i);
    compare("evt_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
